// File: rtl/alu_sys_pkg.sv
// Shared ALU-subsystem types: sender FSM state encoding and frame byte-count helper.
// Pure declarations; no logic, no latency or flow-control behaviour of its own.
package alu_sys_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } sender_state_e;

    // Number of BYTE_W-wide bytes needed to carry a 2*WIDTH-bit ALU result.
    function automatic int byte_count(input int width, input int byte_w);
        return (2 * width) / byte_w;
    endfunction

endpackage

// File: rtl/alu_result_sender_if.sv
// ALU-result / transmitter handshake bundle between the ALU side and the byte sender.
// Plain wires; the sender drives the TX and status side, the environment the rest.
interface alu_result_sender_if #(
    parameter int WIDTH  = 16,
    parameter int BYTE_W = 8
);
    logic [2*WIDTH-1:0] ALU_OUT;
    logic               OUT_Valid;
    logic               TX_Busy;
    logic [BYTE_W-1:0]  TX_P_DATA;
    logic               TX_D_VLD;
    logic               Sender_Busy;
    logic               Drop_Pulse;

    modport slave (
        input  ALU_OUT, OUT_Valid, TX_Busy,
        output TX_P_DATA, TX_D_VLD, Sender_Busy, Drop_Pulse
    );

    modport master (
        output ALU_OUT, OUT_Valid, TX_Busy,
        input  TX_P_DATA, TX_D_VLD, Sender_Busy, Drop_Pulse
    );
endinterface

// File: rtl/alu_sender_fsm.sv
// Frame sequencer: state, byte index and TX handshake; strobe one cycle after capture.
// Waits for TX_Busy to rise then fall per byte; results arriving while busy are dropped.
module alu_sender_fsm
    import alu_sys_pkg::*;
#(
    parameter int FRAME = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             out_vld,
    input  logic             tx_busy,
    output logic             tx_d_vld,
    output logic             sender_busy,
    output logic             drop_pulse,
    output logic             load_first,
    output logic             load_next,
    output logic [CNT_W-1:0] byte_idx
);

    sender_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             drop_q, drop_d;

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        drop_d     = out_vld && (state_q != IDLE);
        load_first = 1'b0;
        load_next  = 1'b0;
        case (state_q)
            IDLE: begin
                if (out_vld) begin
                    state_d    = SEND;
                    cnt_d      = '0;
                    load_first = 1'b1;
                end
            end
            SEND:    state_d = WAIT_HI;
            WAIT_HI: if (tx_busy) state_d = WAIT_LO;
            WAIT_LO: begin
                if (!tx_busy) begin
                    if (cnt_q == CNT_W'(FRAME - 1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d   = SEND;
                        cnt_d     = cnt_q + CNT_W'(1);
                        load_next = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // byte_idx names the byte being loaded for the upcoming SEND cycle
    assign byte_idx    = cnt_d;
    assign tx_d_vld    = (state_q == SEND);
    assign sender_busy = (state_q != IDLE);
    assign drop_pulse  = drop_q;

endmodule

// File: rtl/alu_result_sender.sv
// Serialises a 2*WIDTH ALU result into BYTE_W bytes, LSB first; first strobe 1 cycle after capture.
// Paced by TX_Busy per byte; ALU_SENDER_CHKSUM_EN appends an XOR checksum byte to each frame.
module alu_result_sender
    import alu_sys_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int BYTE_W = 8
) (
    input  logic                clk,
    input  logic                RST,
    alu_result_sender_if.slave  bus
);

    localparam int N = byte_count(WIDTH, BYTE_W);
`ifdef ALU_SENDER_CHKSUM_EN
    localparam int FRAME = N + 1;
`else
    localparam int FRAME = N;
`endif
    localparam int CNT_W = $clog2(FRAME + 1);

    logic [2*WIDTH-1:0] cap_q, cap_d;
    logic [BYTE_W-1:0]  tx_dat_q, tx_dat_d;
    logic [BYTE_W-1:0]  next_byte;
    logic               load_first, load_next;
    logic [CNT_W-1:0]   byte_idx;

    alu_sender_fsm #(
        .FRAME (FRAME),
        .CNT_W (CNT_W)
    ) u_fsm (
        .clk         (clk),
        .RST         (RST),
        .out_vld     (bus.OUT_Valid),
        .tx_busy     (bus.TX_Busy),
        .tx_d_vld    (bus.TX_D_VLD),
        .sender_busy (bus.Sender_Busy),
        .drop_pulse  (bus.Drop_Pulse),
        .load_first  (load_first),
        .load_next   (load_next),
        .byte_idx    (byte_idx)
    );

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            cap_q    <= '0;
            tx_dat_q <= '0;
        end else begin
            cap_q    <= cap_d;
            tx_dat_q <= tx_dat_d;
        end
    end

`ifdef ALU_SENDER_CHKSUM_EN
    logic [BYTE_W-1:0] chksum;
    always_comb begin
        chksum = '0;
        for (int i = 0; i < N; i++) chksum = chksum ^ cap_q[i*BYTE_W +: BYTE_W];
    end
`endif

    always_comb begin
        next_byte = '0;
        for (int i = 0; i < N; i++) begin
            if (byte_idx == CNT_W'(i)) next_byte = cap_q[i*BYTE_W +: BYTE_W];
        end
`ifdef ALU_SENDER_CHKSUM_EN
        if (byte_idx == CNT_W'(N)) next_byte = chksum;
`endif
    end

    // Byte 0 comes straight from ALU_OUT so it is ready in the SEND cycle right after capture
    always_comb begin
        cap_d    = cap_q;
        tx_dat_d = tx_dat_q;
        if (load_first) begin
            cap_d    = bus.ALU_OUT;
            tx_dat_d = bus.ALU_OUT[BYTE_W-1:0];
        end else if (load_next) begin
            tx_dat_d = next_byte;
        end
    end

    assign bus.TX_P_DATA = tx_dat_q;

endmodule

// File: doc/alu_result_sender.md
ALU_RESULT_SENDER -- requirements
Module: alu_result_sender

Interface
REQ-001 Parameter WIDTH, default 16, ALU operand width; result width is 2*WIDTH; WIDTH SHALL be a multiple of 4.
REQ-002 Parameter BYTE_W, default 8, width of the transmit data word.
REQ-003 Reset is RST, asynchronous, active-low; clock is clk.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 RST  input  1  asynchronous active-low reset.
REQ-006 ALU_OUT  input  2*WIDTH  ALU result, sampled only when OUT_Valid=1.
REQ-007 OUT_Valid  input  1  single-cycle result-valid flag from the ALU.
REQ-008 TX_Busy  input  1  serial transmitter busy; high while a word is being shifted out.
REQ-009 TX_P_DATA  output  BYTE_W  parallel byte to the transmitter.
REQ-010 TX_D_VLD  output  1  single-cycle byte-valid strobe to the transmitter.
REQ-011 Sender_Busy  output  1  high from capture until the last byte is accepted and completed.
REQ-012 Drop_Pulse  output  1  single-cycle pulse when a result arrives while Sender_Busy=1.

Function
REQ-013 The block SHALL capture ALU_OUT into an internal register on the clk edge where OUT_Valid=1 and state is IDLE, and raise Sender_Busy on that edge.
REQ-014 FSM states: IDLE, SEND, WAIT_HI, WAIT_LO; IDLE->SEND on capture; SEND->WAIT_HI unconditionally; WAIT_HI->WAIT_LO when TX_Busy=1; WAIT_LO->SEND when TX_Busy=0 and bytes remain; WAIT_LO->IDLE when TX_Busy=0 and none remain.
REQ-015 In SEND, TX_P_DATA SHALL present the current byte and TX_D_VLD SHALL be 1 for exactly one cycle; TX_P_DATA SHALL hold that byte until the next SEND.
REQ-016 Bytes SHALL be sent least-significant first; byte count N = 2*WIDTH/BYTE_W, byte counter wraps to 0 on return to IDLE.
REQ-017 First TX_D_VLD SHALL occur one cycle after the capture edge.
REQ-018 If TX_Busy is already 1 in WAIT_HI on its first cycle, the FSM SHALL advance to WAIT_LO immediately.
REQ-019 OUT_Valid while not IDLE SHALL be ignored, result not stored, Drop_Pulse=1 next cycle; OUT_Valid in the cycle the FSM enters IDLE SHALL be dropped too.
REQ-020 Sender_Busy SHALL fall on the edge entering IDLE; a new capture is possible the following cycle.

Reset
REQ-021 On RST=0: state IDLE, byte counter 0, capture register 0, TX_P_DATA=0, TX_D_VLD=0, Sender_Busy=0, Drop_Pulse=0.
REQ-022 Reset mid-frame SHALL abort the frame with no further TX_D_VLD; remaining bytes are discarded.

Configuration
REQ-023 Macro ALU_SENDER_CHKSUM_EN defined: after the N result bytes, one extra byte equal to the XOR of all N bytes SHALL be sent using the same SEND/WAIT handshake, frame length N+1.
REQ-024 Macro ALU_SENDER_CHKSUM_EN undefined: frame length N, no checksum logic present.

Structure
REQ-025 FSM state encoding and the byte-count derivation function SHALL live in shared package alu_sys_pkg.
REQ-026 A sub-module alu_sender_fsm holding state, byte counter and handshake logic is natural; the datapath (capture register, byte mux, checksum) stays in the top.

Verification (WIDTH=16, BYTE_W=8)
REQ-027 ALU_OUT=32'h1234_ABCD, OUT_Valid pulse, TX_Busy high 3 cycles after each strobe -> TX_P_DATA sequence CD, AB, 34, 12, four one-cycle TX_D_VLD strobes, Sender_Busy low after the fourth TX_Busy fall.
REQ-028 Same stimulus with ALU_SENDER_CHKSUM_EN -> fifth byte 0x40, five strobes.
REQ-029 Second OUT_Valid with ALU_OUT=32'hFFFF_0000 during byte 2 -> Drop_Pulse one cycle, transmitted bytes unchanged CD, AB, 34, 12.
REQ-030 RST low during WAIT_LO of byte 2 -> all outputs 0 immediately, no further strobes; a new OUT_Valid with 32'h0000_00A5 after release -> bytes A5, 00, 00, 00.
REQ-031 TX_Busy tied high before first strobe, released 10 cycles later -> FSM passes WAIT_HI in one cycle, second strobe only after TX_Busy falls.
REQ-032 Back-to-back results 32'h1 then 32'h2, second issued the cycle after Sender_Busy falls -> both frames sent complete, no Drop_Pulse.
